// File: rtl/fpany_accum_widen_lanes.sv
// Multi-lane streaming FP accumulator: narrow mult results widened and summed
// into wide per-lane psums, one result per packet with sticky saturation.
module fpany_accum_widen_lanes #(
    parameter int EXPO_WIDTH_MULT = 3,
    parameter int MANT_WIDTH_MULT = 4,
    parameter int EXPO_WIDTH_PSUM = EXPO_WIDTH_MULT + 3,
    parameter int MANT_WIDTH_PSUM = MANT_WIDTH_MULT + 1,
    parameter int LANES = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_last,
    input  logic [LANES*(1+EXPO_WIDTH_MULT+MANT_WIDTH_MULT)-1:0] in_a,
    input  logic [LANES*(1+EXPO_WIDTH_PSUM+MANT_WIDTH_PSUM)-1:0] in_psum,
    output logic out_valid,
    input  logic out_ready,
    output logic [LANES*(1+EXPO_WIDTH_PSUM+MANT_WIDTH_PSUM)-1:0] out_psum,
    output logic [LANES-1:0] out_sat,
    output logic [CNT_WIDTH-1:0] out_count
);
    localparam int EM = EXPO_WIDTH_MULT;
    localparam int MM = MANT_WIDTH_MULT;
    localparam int EP = EXPO_WIDTH_PSUM;
    localparam int MP = MANT_WIDTH_PSUM;
    localparam int AW = 1 + EM + MM;
    localparam int PW = 1 + EP + MP;
    localparam int SW = MP + 2;
    localparam int EX = EP + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    function automatic logic [PW-1:0] widen(input logic [AW-1:0] a);
        logic [EP-1:0] e;
        logic [MP-1:0] m;
        e = '0;
        m = '0;
        e[EM-1:0] = a[MM +: EM];
        m[MP-1 -: MM] = a[MM-1:0];
        return {a[AW-1], e, m};
    endfunction

    // Returns {sat, sum}; exponent field zero encodes zero.
    function automatic logic [PW:0] fadd(input logic [PW-1:0] x,
                                         input logic [PW-1:0] y);
        logic sx, sy, sb, x_big, found;
        logic [EP-1:0] ex, ey, eb, es, d;
        logic [MP-1:0] mx, my;
        logic [SW-1:0] gb, gs, n;
        logic [SW:0] sum;
        logic signed [EX-1:0] e;
        logic [MP:0] mr;
        int lz;
        sx = x[PW-1];
        sy = y[PW-1];
        ex = x[PW-2 -: EP];
        ey = y[PW-2 -: EP];
        mx = x[MP-1:0];
        my = y[MP-1:0];
        if (ex == '0 && ey == '0) return '0;
        if (ex == '0) return {1'b0, y};
        if (ey == '0) return {1'b0, x};
        x_big = (ex > ey) || (ex == ey && mx >= my);
        sb = x_big ? sx : sy;
        eb = x_big ? ex : ey;
        es = x_big ? ey : ex;
        gb = {1'b1, (x_big ? mx : my), 1'b0};
        gs = {1'b1, (x_big ? my : mx), 1'b0};
        d = eb - es;
        gs = (int'(d) >= SW) ? '0 : gs >> d;
        if (sx == sy) sum = {1'b0, gb} + {1'b0, gs};
        else          sum = {1'b0, gb} - {1'b0, gs};
        if (sum == '0) return '0;
        e = $signed({2'b00, eb});
        if (sum[SW]) begin
            n = sum[SW:1];
            e = e + EX'(1);
        end else begin
            lz = 0;
            found = 1'b0;
            for (int i = SW - 1; i >= 0; i--) begin
                if (!found) begin
                    if (sum[i]) found = 1'b1;
                    else lz++;
                end
            end
            n = sum[SW-1:0] << lz;
            e = e - EX'(lz);
        end
        // Guard bit rounds half-up; a mantissa carry bumps the exponent.
        mr = {1'b0, n[SW-2:1]} + {{MP{1'b0}}, n[0]};
        if (mr[MP]) e = e + EX'(1);
        if (e > $signed({2'b00, {EP{1'b1}}}))
            return {1'b1, sb, {EP{1'b1}}, {MP{1'b1}}};
        if (e <= $signed(EX'(0))) return '0;
        return {1'b0, sb, e[EP-1:0], mr[MP-1:0]};
    endfunction

    logic [1:0] state;
    logic [LANES*PW-1:0] acc, nxt_acc;
    logic [LANES-1:0] sat, nxt_sat;
    logic [CNT_WIDTH-1:0] cnt, nxt_cnt;
    logic [PW-1:0] base;
    logic [PW:0] res;
    logic accept, first;

    assign in_ready = !out_valid || out_ready;
    assign accept = in_valid && in_ready;
    assign first = (state != S_ACC);

    always_comb begin
        nxt_acc = '0;
        nxt_sat = '0;
        base = '0;
        res = '0;
        for (int i = 0; i < LANES; i++) begin
            base = first ? in_psum[i*PW +: PW] : acc[i*PW +: PW];
            res = fadd(base, widen(in_a[i*AW +: AW]));
            nxt_acc[i*PW +: PW] = res[PW-1:0];
            nxt_sat[i] = res[PW] | (~first & sat[i]);
        end
        if (first) nxt_cnt = CNT_WIDTH'(1);
        else if (&cnt) nxt_cnt = cnt;
        else nxt_cnt = cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            acc <= '0;
            sat <= '0;
            cnt <= '0;
            out_valid <= 1'b0;
            out_psum <= '0;
            out_sat <= '0;
            out_count <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
                acc <= nxt_acc;
                sat <= nxt_sat;
                cnt <= nxt_cnt;
                if (in_last) begin
                    out_psum <= nxt_acc;
                    out_sat <= nxt_sat;
                    out_count <= nxt_cnt;
                    out_valid <= 1'b1;
                    state <= S_HOLD;
                end else begin
                    state <= S_ACC;
                end
            end else if (out_valid && out_ready) begin
                state <= S_IDLE;
            end
        end
    end
endmodule

// File: doc/fpany_accum_widen_lanes.md
Name: fpany_accum_widen_lanes

Overview:
- Multi-lane, handshaked, sequential floating-point accumulator for the FPApprox MAC datapath.
- Each lane adds a stream of narrow multiplier results into a wide partial sum. The sum is seeded from an input psum on the first beat of a packet and released on the last beat.
- It extends the widening FPAny adder with:
  - zero operands
  - full leading-zero renormalisation
  - round-carry exponent fix-up
  - exponent saturation and underflow flush
  - a valid/ready streaming interface
  - per-packet beat counting

Parameters:
- EXPO_WIDTH_MULT, 3: multiplier-result exponent width. Bias is 2^(EXPO_WIDTH_MULT-1)-1 in both formats.
- MANT_WIDTH_MULT, 4: multiplier-result mantissa width.
- EXPO_WIDTH_PSUM, EXPO_WIDTH_MULT+3: psum exponent width. Must be >= EXPO_WIDTH_MULT.
- MANT_WIDTH_PSUM, MANT_WIDTH_MULT+1: psum mantissa width. Must be >= MANT_WIDTH_MULT.
- LANES, 4: number of independent accumulator lanes.
- CNT_WIDTH, 8: width of the beat counter.
- Derived widths: AW = 1+EXPO_WIDTH_MULT+MANT_WIDTH_MULT; PW = 1+EXPO_WIDTH_PSUM+MANT_WIDTH_PSUM.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_last  in  1  final beat of packet.
- in_a  in  LANES*AW  mult results; lane i occupies [i*AW +: AW].
- in_psum  in  LANES*PW  seed psums; sampled only on the first beat of a packet.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_psum  out  LANES*PW  accumulated psums.
- out_sat  out  LANES  sticky per-lane saturation flag for the packet.
- out_count  out  CNT_WIDTH  beats in the packet, saturating at 2^CNT_WIDTH-1.

Behaviour:
- Reset (synchronous, active-high): state IDLE, out_valid=0, out_psum=0, out_sat=0, out_count=0, all accumulators 0. Reset mid-packet discards the partial packet.
- FSM states:
  - IDLE: no packet open. An accepted beat is a first beat: acc = in_psum + widen(in_a), count=1.
  - ACC: packet open. An accepted beat does acc = acc + widen(in_a), count+1 (saturating).
  - HOLD: result presented.
  - Any accepted beat with in_last: out_psum/out_sat/out_count are registered from the post-add values, out_valid=1, go to HOLD. Latency is 1 cycle from the last-beat accept to out_valid.
- Transitions:
  - in_ready = !out_valid || out_ready.
  - In HOLD, if out_valid && out_ready and no beat is accepted: go IDLE, out_valid=0.
  - If the result drains and a beat is accepted in the same cycle, that beat is a first beat. Non-last: go ACC. Last: stay HOLD with the new result.
  - out_* are stable while out_valid && !out_ready.
  - in_valid=0 in ACC keeps the packet open indefinitely.
- Widening: exponent is zero-extended (no rebias). Mantissa is left-aligned and zero-padded. Sign is copied.
- Zero encoding: exponent field == 0 means zero, whatever the mantissa.
  - One operand zero: result = the other operand.
  - Both operands zero: result is +0 (all bits 0).
- Add, per lane, combinational before the accumulator register:
  - Swap so the larger exponent wins; on a tie, the larger mantissa wins.
  - Significand = {1, mant, guard 0}.
  - Shift the smaller operand right by the exponent difference; a shift >= MANT_WIDTH_PSUM+2 gives 0.
  - Same signs: add. Different signs: subtract (big - small).
  - Result sign = sign of the larger operand.
- Normalise:
  - Carry out: shift right 1, exponent+1.
  - Otherwise shift left by the leading-zero count (0 .. MANT_WIDTH_PSUM+1), exponent minus that count.
  - Exact zero difference: result is +0.
- Round: half-up on the guard bit. A mantissa carry from rounding gives exponent+1, mantissa 0.
- Saturation: a result exponent > 2^EXPO_WIDTH_PSUM-1 gives exponent all ones, mantissa all ones, sign kept, and sets the lane's sat flag. The sat flag is sticky until the next first beat.
- Underflow: a result exponent <= 0 is flushed to +0. No sat flag.
- Lanes share the handshake and count; arithmetic is fully independent per lane.

Test Plan (defaults unless noted; bias 3; lane 0 unless noted):
1. Single-beat packet: in_psum=0_000011_00000 (1.0), in_a=0_011_0000 (1.0), in_last=1 -> next cycle out_valid=1, out_psum=0_000100_00000 (2.0), out_count=1, out_sat=0.
2. Three-beat packet: seed +0, in_a=1.0 on each beat, last on beat 3 -> out_psum=0_000100_10000 (3.0), out_count=3.
3. Cancellation and renormalisation:
   - psum 0_000011_11000 (1.75) + a 1_011_1000 (-1.5) -> 0_000001_00000 (0.25, 2-bit left shift).
   - psum 1.0 + a -1.0 -> all zeros.
4. Saturation, with EXPO_WIDTH_PSUM=3 override: psum 0_111_11111 + a 0_111_1111 -> out_psum=0_111_11111, out_sat=1.
5. Backpressure:
   - Result held with out_ready=0 for 5 cycles -> in_ready=0 and out_* stable throughout.
   - Then out_ready=1 with in_valid=1 -> drain and accept the new first beat in the same cycle.
6. Reset and lane independence:
   - rst after 2 beats -> out_valid=0; the next packet is seeded from in_psum only.
   - Lanes 0..3 given 1+1, -1+-1, 0+1.0, 2^40+1.0 simultaneously -> 2.0, -2.0, 1.0, 2^40 (operand shifted out).
